// File: rtl/data_mover_sched.sv
// Round-robin descriptor scheduler: per-channel FIFOs feeding one data mover transfer at a time.
// Optional sticky completion interrupt when DM_SCHED_IRQ_EN is defined.
module data_mover_sched #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned QDEPTH     = 4,
  localparam int unsigned CH_W      = $clog2(NUM_CH),
  localparam int unsigned CNT_W     = $clog2(QDEPTH) + 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CH_W-1:0]       cpu_ch,
  input  logic [ADDR_WIDTH-1:0] cpu_ddr_addr,
  input  logic [ADDR_WIDTH-1:0] cpu_bram_addr,
  input  logic [ADDR_WIDTH-1:0] cpu_length,
  input  logic                  cpu_valid,
  output logic                  cpu_ready,
  output logic [NUM_CH-1:0]     ch_busy,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] dm_ddr_addr,
  output logic [ADDR_WIDTH-1:0] dm_bram_addr,
  output logic [ADDR_WIDTH-1:0] dm_length,
  output logic [CH_W-1:0]       dm_ch,
  output logic                  dm_valid,
  input  logic                  dm_ready,
  input  logic                  dm_done,
  output logic                  done_valid,
  output logic [CH_W-1:0]       done_ch,
  input  logic [NUM_CH-1:0]     irq_clear,
  output logic [NUM_CH-1:0]     irq_status,
  output logic                  irq
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_AWAIT} state_t;

  state_t                r_state;
  logic [CH_W-1:0]       r_rr_last;
  logic [ADDR_WIDTH-1:0] r_dm_ddr, r_dm_bram, r_dm_len;
  logic [CH_W-1:0]       r_dm_ch;
  logic                  r_dm_valid;
  logic                  r_done_valid;
  logic [CH_W-1:0]       r_done_ch;

  logic                  w_push, w_pop, w_any;
  logic [CH_W-1:0]       w_grant;
  logic [NUM_CH-1:0]     w_push_oh, w_pop_oh, w_nonempty, w_full, w_ch_busy;
  logic [ADDR_WIDTH-1:0] w_head_ddr  [NUM_CH];
  logic [ADDR_WIDTH-1:0] w_head_bram [NUM_CH];
  logic [ADDR_WIDTH-1:0] w_head_len  [NUM_CH];

  // Zero-length descriptors complete the handshake but never enter a FIFO.
  assign cpu_ready = !w_full[cpu_ch];
  assign w_push    = cpu_valid && cpu_ready && (cpu_length != '0);
  assign w_pop     = (r_state == S_IDLE) && w_any;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ADDR_WIDTH-1:0] r_ddr  [QDEPTH];
    logic [ADDR_WIDTH-1:0] r_bram [QDEPTH];
    logic [ADDR_WIDTH-1:0] r_len  [QDEPTH];
    logic [PTR_W-1:0]      r_wptr, r_rptr;
    logic [CNT_W-1:0]      r_cnt;

    assign w_push_oh[g]   = w_push && (cpu_ch == CH_W'(g));
    assign w_pop_oh[g]    = w_pop && (w_grant == CH_W'(g));
    assign w_nonempty[g]  = (r_cnt != '0);
    assign w_full[g]      = (r_cnt >= CNT_W'(QDEPTH));
    assign w_head_ddr[g]  = r_ddr[r_rptr];
    assign w_head_bram[g] = r_bram[r_rptr];
    assign w_head_len[g]  = r_len[r_rptr];
    assign w_ch_busy[g]   = w_nonempty[g] || ((r_state != S_IDLE) && (r_dm_ch == CH_W'(g)));

    always_ff @(posedge aclk) begin
      if (w_push_oh[g]) begin
        r_ddr[r_wptr]  <= cpu_ddr_addr;
        r_bram[r_wptr] <= cpu_bram_addr;
        r_len[r_wptr]  <= cpu_length;
      end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push_oh[g]) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop_oh[g])  r_rptr <= r_rptr + PTR_W'(1);
        case ({w_push_oh[g], w_pop_oh[g]})
          2'b10:   r_cnt <= r_cnt + CNT_W'(1);
          2'b01:   r_cnt <= r_cnt - CNT_W'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  // Search starts one past the last grant so every channel gets a turn.
  always_comb begin
    logic [CH_W-1:0] cand;
    w_any   = 1'b0;
    w_grant = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((32'(r_rr_last) + k) % NUM_CH);
      if (!w_any && w_nonempty[cand]) begin
        w_any   = 1'b1;
        w_grant = cand;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_rr_last    <= CH_W'(NUM_CH - 1);
      r_dm_ddr     <= '0;
      r_dm_bram    <= '0;
      r_dm_len     <= '0;
      r_dm_ch      <= '0;
      r_dm_valid   <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_ch    <= '0;
    end else begin
      r_done_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_dm_ddr   <= w_head_ddr[w_grant];
          r_dm_bram  <= w_head_bram[w_grant];
          r_dm_len   <= w_head_len[w_grant];
          r_dm_ch    <= w_grant;
          r_rr_last  <= w_grant;
          r_dm_valid <= 1'b1;
          r_state    <= S_ISSUE;
        end
        S_ISSUE: if (dm_ready) begin
          r_dm_valid <= 1'b0;
          r_state    <= S_AWAIT;
        end
        S_AWAIT: if (dm_done) begin
          r_done_valid <= 1'b1;
          r_done_ch    <= r_dm_ch;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dm_ddr_addr  = r_dm_ddr;
  assign dm_bram_addr = r_dm_bram;
  assign dm_length    = r_dm_len;
  assign dm_ch        = r_dm_ch;
  assign dm_valid     = r_dm_valid;
  assign done_valid   = r_done_valid;
  assign done_ch      = r_done_ch;
  assign ch_busy      = w_ch_busy;
  assign busy         = |w_ch_busy;

`ifdef DM_SCHED_IRQ_EN
  logic [NUM_CH-1:0] r_irq_status;
  logic              r_irq;

  // A new completion outranks a clear of the same bit in the same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_irq_status <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_irq_status <= (r_irq_status & ~irq_clear) |
                      (r_done_valid ? (NUM_CH'(1) << r_done_ch) : '0);
      r_irq        <= |r_irq_status;
    end
  end

  assign irq_status = r_irq_status;
  assign irq        = r_irq;
`else
  logic w_unused_irq_clear;
  assign w_unused_irq_clear = ^irq_clear;
  assign irq_status = '0;
  assign irq        = 1'b0;
`endif

endmodule
